pulse_window_stats: RTL
=======================

PULSE_WINDOW_STATS -- requirements
Module: pulse_window_stats

Interface
REQ-001 Parameter DEPTH, default 600, sets window length in samples (one per LCD waveform column).
REQ-002 Parameter SW, default 16, sets stored sample width.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  sample acceptance enable.
REQ-006 i_clear  input  1  synchronous window/accumulator clear.
REQ-007 i_sample_valid  input  1  one-cycle strobe, new pulse count available.
REQ-008 i_sample  input  32  pulse count for the elapsed time interval.
REQ-009 o_data_update  output  1  one-cycle strobe, all outputs refreshed (drives draw adapter iData_Update).
REQ-010 o_pulse_counter  output  32  last accepted sample, unsaturated.
REQ-011 o_accumulated  output  32  saturating sum of accepted samples since reset/clear.
REQ-012 o_max  output  SW  maximum stored sample in window.
REQ-013 o_min  output  SW  minimum stored sample in window.
REQ-014 o_count  output  10  valid entries in window, 0..DEPTH.
REQ-015 o_busy  output  1  high whenever state is not IDLE.
REQ-016 o_drop  output  1  one-cycle strobe, sample rejected.

Function
REQ-017 Window storage shall be a DEPTH x SW single-port synchronous RAM with 1-cycle read latency, addressed by wr_ptr.
REQ-018 Stored value shall be i_sample saturated to 2^SW-1 when i_sample >= 2^SW.
REQ-019 States: IDLE, RD_OLD, UPDATE, SCAN, SCAN_LAST, DONE.
REQ-020 IDLE: i_sample_valid with en=1 shall latch sample and go to RD_OLD; with en=0 sample shall be ignored, no o_drop.
REQ-021 RD_OLD: present wr_ptr to RAM; next state UPDATE.
REQ-022 UPDATE: capture evicted value (valid only if o_count==DEPTH), write new sample at wr_ptr, advance wr_ptr (DEPTH-1 wraps to 0), increment o_count saturating at DEPTH, add sample to o_accumulated saturating at 32'hFFFF_FFFF, set o_pulse_counter.
REQ-023 UPDATE, no eviction or evicted value strictly between o_min and o_max: o_max=max(o_max,new), o_min=min(o_min,new) (first sample after empty sets both to new); next state DONE.
REQ-024 UPDATE, evicted value equals o_max or o_min: next state SCAN with scan address 0, running max/min seeded from new sample.
REQ-025 SCAN reads addresses 0..DEPTH-1 one per cycle, folding each returned word into running max/min; SCAN_LAST folds final word, loads o_max/o_min; next DONE.
REQ-026 DONE: assert o_data_update for exactly one cycle; return to IDLE.
REQ-027 Latency valid->o_data_update: 3 cycles on incremental path; DEPTH+4 cycles on scan path.
REQ-028 o_max/o_min shall not change during SCAN; they change only on the cycle entering DONE.
REQ-029 i_sample_valid while o_busy=1 shall assert o_drop the next cycle and discard the sample; in-flight operation unaffected.
REQ-030 en falling mid-operation shall not abort; operation completes with o_data_update.
REQ-031 i_clear has priority over everything: next cycle state=IDLE, wr_ptr=0, o_count=0, o_accumulated=0, o_max=0, o_min=0, o_pulse_counter=0; RAM contents not cleared; no o_data_update for aborted operation.
REQ-032 i_clear and i_sample_valid in same cycle: sample discarded, no o_drop.
REQ-033 o_count==0: o_max=o_min=0.

Reset
REQ-034 On rst_n low all outputs shall be 0, state IDLE, wr_ptr 0, scan counter 0; RAM content undefined and unused until written.
REQ-035 Reset release shall require no initialisation cycles; first sample accepted in first cycle after deassertion.

Verification
REQ-036 After reset, samples 5,9,3 spaced 10 cycles -> each o_data_update 3 cycles after valid; final o_max=9, o_min=3, o_count=3, o_accumulated=17.
REQ-037 Sample 32'h0001_2345 -> o_pulse_counter=32'h0001_2345, o_max=16'hFFFF, o_accumulated increases by 32'h0001_2345.
REQ-038 DEPTH=4, samples 8,1,5,6 then 2 -> 8 evicted, SCAN, o_data_update 8 cycles after valid, o_max=6, o_min=1, o_count=4; wr_ptr wraps to 1.
REQ-039 Valid pulses on consecutive cycles 7,7 -> second gives o_drop next cycle, o_count +1 only.
REQ-040 i_clear during SCAN -> no o_data_update, all outputs 0 next cycle, next sample 4 gives o_max=o_min=4, o_count=1.
REQ-041 o_accumulated at 32'hFFFF_FFF0 plus sample 32 -> holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pulse_window_stats.sv
// Sliding-window pulse statistics: keeps the last DEPTH samples in block RAM and
// reports last/accumulated/max/min/count, rescanning the window when an extreme is evicted.
module pulse_window_stats #(
  parameter int DEPTH = 600,
  parameter int SW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          i_clear,
  input  logic          i_sample_valid,
  input  logic [31:0]   i_sample,
  output logic          o_data_update,
  output logic [31:0]   o_pulse_counter,
  output logic [31:0]   o_accumulated,
  output logic [SW-1:0] o_max,
  output logic [SW-1:0] o_min,
  output logic [9:0]    o_count,
  output logic          o_busy,
  output logic          o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SW-1:0] SAT_VAL   = '1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [9:0]    FULL_CNT  = 10'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, RD_OLD, UPDATE, SCAN, SCAN_LAST, DONE
  } state_t;

  state_t        stateReg, stateNext;
  logic [31:0]   sampleReg;
  logic [AW-1:0] wrPtrReg;
  logic [AW-1:0] scanAddrReg;
  logic [SW-1:0] runMaxReg, runMinReg;

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] ramRdata;
  logic [AW-1:0] ramAddr;
  logic          ramWe;

  logic [SW-1:0] storedVal;
  logic [32:0]   accSum;
  logic          countFull;
  logic          evictHit;
  logic [SW-1:0] foldMax, foldMin;

  assign storedVal = (sampleReg > 32'(SAT_VAL)) ? SAT_VAL : sampleReg[SW-1:0];
  assign accSum    = {1'b0, o_accumulated} + {1'b0, sampleReg};
  assign countFull = (o_count == FULL_CNT);
  assign foldMax   = (ramRdata > runMaxReg) ? ramRdata : runMaxReg;
  assign foldMin   = (ramRdata < runMinReg) ? ramRdata : runMinReg;
  assign o_busy    = (stateReg != IDLE);

  // Single-port window RAM, read-first, one cycle read latency
  assign ramAddr = (stateReg == SCAN) ? scanAddrReg : wrPtrReg;
  assign ramWe   = (stateReg == UPDATE) && !i_clear;

  always_ff @(posedge clk) begin
    if (ramWe) begin
      mem[ramAddr] <= storedVal;
    end
    ramRdata <= mem[ramAddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    evictHit  = 1'b0;
    case (stateReg)
      IDLE:      if (i_sample_valid && en) stateNext = RD_OLD;
      RD_OLD:    stateNext = UPDATE;
      UPDATE: begin
        // Evicting a current extreme invalidates it, so the whole window is rescanned
        evictHit  = countFull && ((ramRdata == o_max) || (ramRdata == o_min));
        stateNext = evictHit ? SCAN : DONE;
      end
      SCAN:      if (scanAddrReg == LAST_ADDR) stateNext = SCAN_LAST;
      SCAN_LAST: stateNext = DONE;
      DONE:      stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
    if (i_clear) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleReg       <= '0;
      wrPtrReg        <= '0;
      scanAddrReg     <= '0;
      runMaxReg       <= '0;
      runMinReg       <= '0;
      o_data_update   <= 1'b0;
      o_pulse_counter <= '0;
      o_accumulated   <= '0;
      o_max           <= '0;
      o_min           <= '0;
      o_count         <= '0;
      o_drop          <= 1'b0;
    end else if (i_clear) begin
      wrPtrReg        <= '0;
      scanAddrReg     <= '0;
      o_data_update   <= 1'b0;
      o_pulse_counter <= '0;
      o_accumulated   <= '0;
      o_max           <= '0;
      o_min           <= '0;
      o_count         <= '0;
      o_drop          <= 1'b0;
    end else begin
      o_drop        <= i_sample_valid && (stateReg != IDLE);
      o_data_update <= (stateNext == DONE);
      case (stateReg)
        IDLE: begin
          if (i_sample_valid && en) sampleReg <= i_sample;
        end
        UPDATE: begin
          o_pulse_counter <= sampleReg;
          o_accumulated   <= accSum[32] ? 32'hFFFF_FFFF : accSum[31:0];
          wrPtrReg        <= (wrPtrReg == LAST_ADDR) ? '0 : wrPtrReg + AW'(1);
          if (!countFull) o_count <= o_count + 10'd1;
          if (evictHit) begin
            scanAddrReg <= '0;
            runMaxReg   <= storedVal;
            runMinReg   <= storedVal;
          end else if (o_count == 10'd0) begin
            o_max <= storedVal;
            o_min <= storedVal;
          end else begin
            if (storedVal > o_max) o_max <= storedVal;
            if (storedVal < o_min) o_min <= storedVal;
          end
        end
        SCAN: begin
          // Read data lags the address by one cycle; nothing to fold on the first scan cycle
          if (scanAddrReg != '0) begin
            runMaxReg <= foldMax;
            runMinReg <= foldMin;
          end
          scanAddrReg <= (scanAddrReg == LAST_ADDR) ? '0 : scanAddrReg + AW'(1);
        end
        SCAN_LAST: begin
          o_max <= foldMax;
          o_min <= foldMin;
        end
        default: ;
      endcase
    end
  end

endmodule
